// File: rtl/multicycle_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multicycle_controller_if : control bus between the multicycle controller |
// | and the datapath (opcode/flags in, control strobes out). Rev 1.0        |
// | Optional port IllegalOp exists only when ILLEGAL_TRAP_EN is defined.      |
// +----------------------------------------------------------------------------+
interface multicycle_controller_if;
    logic [6:0] op;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] ImmSrc;
    logic       RegWrite;
    logic       InstrDone;
    logic       MemFault;
`ifdef ILLEGAL_TRAP_EN
    logic       IllegalOp;
`endif

    // Controller side
    modport master (
        input  op, Zero, MemReady,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUOp, ImmSrc, RegWrite, InstrDone, MemFault
`ifdef ILLEGAL_TRAP_EN
        , output IllegalOp
`endif
    );

    // Datapath side
    modport slave (
        output op, Zero, MemReady,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUOp, ImmSrc, RegWrite, InstrDone, MemFault
`ifdef ILLEGAL_TRAP_EN
        , input IllegalOp
`endif
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multicycle_controller : control FSM for the multicycle RV32I core with    |
// | memory-ready timeout. Macro ILLEGAL_TRAP_EN traps unknown opcodes. Rev 1.0 |
// +----------------------------------------------------------------------------+
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    multicycle_controller_if.master        bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_FAULT    = 4'd11,
        S_ILLEGAL  = 4'd12
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t           state_q, state_d, out_st;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fault_q, fault_d;
    logic             wait_st, timeout;

    logic       pc_update, branch, adr_src, mem_write, ir_write, reg_write, instr_done;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;

    assign wait_st = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    // MemReady in the timeout cycle wins: the access completes normally
    assign timeout = (MEM_TIMEOUT > 0) && wait_st && !bus.MemReady && (cnt_q == TIMEOUT_C);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (bus.MemReady) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
`ifdef ILLEGAL_TRAP_EN
                    default:      state_d = S_ILLEGAL;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_d = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (bus.MemReady) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (bus.MemReady) state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_FAULT:    state_d = S_FAULT;
            S_ILLEGAL:  state_d = S_ILLEGAL;
            default:    state_d = S_FETCH;
        endcase
        if (timeout) state_d = S_FAULT;

        cnt_d = '0;
        if (wait_st && !bus.MemReady && (state_d == state_q))
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

        fault_d = fault_q | timeout;
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
    assign illegal_d     = illegal_q | (state_d == S_ILLEGAL);
    assign bus.IllegalOp = illegal_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            fault_q   <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fault_q   <= fault_d;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    // During reset the outputs show FETCH decode with every strobe masked
    assign out_st = reset ? S_FETCH : state_q;

    always_comb begin
        pc_update  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        instr_done = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        case (out_st)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = bus.MemReady;
                pc_update  = bus.MemReady;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
`ifndef ILLEGAL_TRAP_EN
                case (bus.op)
                    OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: instr_done = 1'b0;
                    default:                                  instr_done = 1'b1;
                endcase
`endif
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD:  adr_src = 1'b1;
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                instr_done = bus.MemReady;
            end
            S_EXECUTER: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            S_EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BEQ: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b01;
                branch     = 1'b1;
                instr_done = 1'b1;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            pc_update  = 1'b0;
            branch     = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            instr_done = 1'b0;
        end
    end

    always_comb begin
        imm_src = 2'b00;
        case (bus.op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    assign bus.PCWrite   = pc_update | (branch & bus.Zero);
    assign bus.AdrSrc    = adr_src;
    assign bus.MemWrite  = mem_write;
    assign bus.IRWrite   = ir_write;
    assign bus.ResultSrc = result_src;
    assign bus.ALUSrcA   = alu_src_a;
    assign bus.ALUSrcB   = alu_src_b;
    assign bus.ALUOp     = alu_op;
    assign bus.ImmSrc    = imm_src;
    assign bus.RegWrite  = reg_write;
    assign bus.InstrDone = instr_done;
    assign bus.MemFault  = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_multicycle_controller : per-cycle scoreboard bench for the controller. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_multicycle_controller;

    localparam int E_FETCH = 0, E_DECODE = 1, E_MEMADR = 2, E_MEMREAD = 3, E_MEMWB = 4,
                   E_MEMWRITE = 5, E_EXER = 6, E_EXEI = 7, E_ALUWB = 8, E_BEQ = 9,
                   E_JAL = 10, E_FAULT = 11, E_ILLEGAL = 12;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    typedef struct {
        string       tag;
        logic [16:0] v;
        logic        il;
    } exp_t;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    logic exp_mf;
    logic exp_il;
    exp_t sb[$];
    exp_t cur;

    multicycle_controller_if bus();

    multicycle_controller #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [16:0] obs;
    assign obs = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
                  bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.ImmSrc,
                  bus.RegWrite, bus.InstrDone, bus.MemFault};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Expected outputs for a given state, straight from the state/output table
    function automatic logic [16:0] ev(input int st, input logic rst, input logic [6:0] opc,
                                       input logic z, input logic mr, input logic mf);
        logic pcu, br, adr, mw, irw, rw, dn;
        logic [1:0] rs, sa, sbv, ao, imm;
        pcu = 0; br = 0; adr = 0; mw = 0; irw = 0; rw = 0; dn = 0;
        rs = 2'b00; sa = 2'b00; sbv = 2'b00; ao = 2'b00; imm = 2'b00;
        case (st)
            E_FETCH:    begin sbv = 2'b10; rs = 2'b10; irw = mr; pcu = mr; end
            E_DECODE: begin
                sa = 2'b01; sbv = 2'b01;
`ifndef ILLEGAL_TRAP_EN
                dn = !(opc == OP_LW || opc == OP_SW || opc == OP_R || opc == OP_I ||
                       opc == OP_BEQ || opc == OP_JAL);
`endif
            end
            E_MEMADR:   begin sa = 2'b10; sbv = 2'b01; end
            E_MEMREAD:  adr = 1;
            E_MEMWB:    begin rs = 2'b01; rw = 1; dn = 1; end
            E_MEMWRITE: begin adr = 1; mw = 1; dn = mr; end
            E_EXER:     begin sa = 2'b10; ao = 2'b10; end
            E_EXEI:     begin sa = 2'b10; sbv = 2'b01; ao = 2'b10; end
            E_ALUWB:    begin rw = 1; dn = 1; end
            E_BEQ:      begin sa = 2'b10; ao = 2'b01; br = 1; dn = 1; end
            E_JAL:      begin sa = 2'b01; sbv = 2'b10; pcu = 1; end
            default: ;
        endcase
        if (opc == OP_SW) imm = 2'b01;
        else if (opc == OP_BEQ) imm = 2'b10;
        else if (opc == OP_JAL) imm = 2'b11;
        if (rst) begin pcu = 0; br = 0; mw = 0; irw = 0; rw = 0; dn = 0; end
        return {pcu | (br & z), adr, mw, irw, rs, sa, sbv, ao, imm, rw, dn, mf};
    endfunction

    task automatic cyc(input string tag, input logic rst, input logic [6:0] opc,
                       input logic z, input logic mr, input int st);
        exp_t e;
        @(posedge clk);
        #1;
        reset        = rst;
        bus.op       = opc;
        bus.Zero     = z;
        bus.MemReady = mr;
        e.tag = tag;
        e.v   = ev(st, rst, opc, z, mr, exp_mf);
        e.il  = exp_il;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            cur = sb.pop_front();
            check(cur.tag, {15'd0, obs}, {15'd0, cur.v});
`ifdef ILLEGAL_TRAP_EN
            check({cur.tag, "_ill"}, {31'd0, bus.IllegalOp}, {31'd0, cur.il});
`endif
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        exp_mf  = 1'b0;
        exp_il  = 1'b0;
        reset        = 1'b1;
        bus.op       = OP_R;
        bus.Zero     = 1'b0;
        bus.MemReady = 1'b1;

        cyc("rst0", 1, OP_R, 0, 1, E_FETCH);
        cyc("rst1", 1, OP_R, 0, 1, E_FETCH);

        cyc("r_fetch",  0, OP_R, 0, 1, E_FETCH);
        cyc("r_decode", 0, OP_R, 0, 1, E_DECODE);
        cyc("r_exec",   0, OP_R, 0, 1, E_EXER);
        cyc("r_wb",     0, OP_R, 0, 1, E_ALUWB);

        cyc("lw_fetch_w", 0, OP_LW, 0, 0, E_FETCH);
        cyc("lw_fetch",   0, OP_LW, 0, 1, E_FETCH);
        cyc("lw_decode",  0, OP_LW, 0, 1, E_DECODE);
        cyc("lw_adr",     0, OP_LW, 0, 1, E_MEMADR);
        for (int i = 0; i < 3; i++) cyc("lw_stall", 0, OP_LW, 0, 0, E_MEMREAD);
        cyc("lw_read", 0, OP_LW, 0, 1, E_MEMREAD);
        cyc("lw_wb",   0, OP_LW, 0, 1, E_MEMWB);

        cyc("beq1_fetch",  0, OP_BEQ, 1, 1, E_FETCH);
        cyc("beq1_decode", 0, OP_BEQ, 1, 1, E_DECODE);
        cyc("beq1_exec",   0, OP_BEQ, 1, 1, E_BEQ);
        cyc("beq0_fetch",  0, OP_BEQ, 0, 1, E_FETCH);
        cyc("beq0_decode", 0, OP_BEQ, 0, 1, E_DECODE);
        cyc("beq0_exec",   0, OP_BEQ, 0, 1, E_BEQ);

        cyc("i_fetch",  0, OP_I, 0, 1, E_FETCH);
        cyc("i_decode", 0, OP_I, 0, 1, E_DECODE);
        cyc("i_exec",   0, OP_I, 0, 1, E_EXEI);
        cyc("i_wb",     0, OP_I, 0, 1, E_ALUWB);

        cyc("jal_fetch",  0, OP_JAL, 0, 1, E_FETCH);
        cyc("jal_decode", 0, OP_JAL, 0, 1, E_DECODE);
        cyc("jal_exec",   0, OP_JAL, 0, 1, E_JAL);
        cyc("jal_wb",     0, OP_JAL, 0, 1, E_ALUWB);

        cyc("sw_fetch",  0, OP_SW, 0, 1, E_FETCH);
        cyc("sw_decode", 0, OP_SW, 0, 1, E_DECODE);
        cyc("sw_adr",    0, OP_SW, 0, 1, E_MEMADR);
        cyc("sw_stall",  0, OP_SW, 0, 0, E_MEMWRITE);
        cyc("sw_write",  0, OP_SW, 0, 1, E_MEMWRITE);

        // Ready arriving exactly at the timeout count completes normally
        cyc("lwb_fetch",  0, OP_LW, 0, 1, E_FETCH);
        cyc("lwb_decode", 0, OP_LW, 0, 1, E_DECODE);
        cyc("lwb_adr",    0, OP_LW, 0, 1, E_MEMADR);
        for (int i = 0; i < 15; i++) cyc("lwb_stall", 0, OP_LW, 0, 0, E_MEMREAD);
        cyc("lwb_read", 0, OP_LW, 0, 1, E_MEMREAD);
        cyc("lwb_wb",   0, OP_LW, 0, 1, E_MEMWB);

        cyc("bad_fetch",  0, OP_BAD, 0, 1, E_FETCH);
        cyc("bad_decode", 0, OP_BAD, 0, 1, E_DECODE);
`ifdef ILLEGAL_TRAP_EN
        exp_il = 1'b1;
        for (int i = 0; i < 3; i++) cyc("bad_trap", 0, OP_BAD, 0, 1, E_ILLEGAL);
        cyc("bad_rst0", 1, OP_R, 0, 1, E_FETCH);
        exp_il = 1'b0;
        cyc("bad_rst1", 1, OP_R, 0, 1, E_FETCH);
`else
        cyc("bad_next_fetch",  0, OP_R, 0, 1, E_FETCH);
        cyc("bad_next_decode", 0, OP_R, 0, 1, E_DECODE);
        cyc("bad_next_exec",   0, OP_R, 0, 1, E_EXER);
        cyc("bad_next_wb",     0, OP_R, 0, 1, E_ALUWB);
`endif

        cyc("to_fetch",  0, OP_SW, 0, 1, E_FETCH);
        cyc("to_decode", 0, OP_SW, 0, 1, E_DECODE);
        cyc("to_adr",    0, OP_SW, 0, 1, E_MEMADR);
        for (int i = 0; i < 16; i++) cyc("to_hold", 0, OP_SW, 0, 0, E_MEMWRITE);
        exp_mf = 1'b1;
        cyc("to_fault0", 0, OP_SW, 0, 0, E_FAULT);
        for (int i = 0; i < 3; i++) cyc("to_fault", 0, OP_SW, 1, 1, E_FAULT);
        cyc("to_rst0", 1, OP_R, 0, 1, E_FETCH);
        exp_mf = 1'b0;
        cyc("to_rst1",  1, OP_R, 0, 1, E_FETCH);
        cyc("to_fetch2", 0, OP_R, 0, 1, E_FETCH);
        cyc("to_decode2", 0, OP_R, 0, 1, E_DECODE);

        @(posedge clk);
        #1;
        check("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
